// File: rtl/cu_pkg.sv
// Shared types and helpers for the multi-cycle control unit.
// Optional illegal-opcode trap is enabled by defining CU_ILLEGAL_TRAP_EN.
package cu_pkg;

  typedef enum logic [2:0] {
    OPC_LW  = 3'd0,
    OPC_SW  = 3'd1,
    OPC_ADD = 3'd2,
    OPC_SUB = 3'd3,
    OPC_AND = 3'd4,
    OPC_OR  = 3'd5,
    OPC_BEQ = 3'd6
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_MEM_LD  = 3'd0,
    CLS_MEM_ST  = 3'd1,
    CLS_ALU     = 3'd2,
    CLS_BR      = 3'd3,
    CLS_ILLEGAL = 3'd4
  } instr_class_e;

  // Callers zero-extend the opcode, so any set bit above [2:0] makes it illegal.
  function automatic logic is_legal(input logic [31:0] op);
    return op <= 32'(OPC_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake, memory status and datapath control bundle.
// illegal_op exists only when CU_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int ALU_OP_W = 2
);
  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                z;
  logic                mem_ready;
  logic                ir_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write;
  logic                beq;
  logic                branch_taken;
  logic                mem_err;
  logic                busy;
`ifdef CU_ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif

  modport master (
    output instr_valid, opcode, z, mem_ready,
    input  instr_ready, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_to_reg, reg_write, beq, branch_taken, mem_err, busy
`ifdef CU_ILLEGAL_TRAP_EN
    , input illegal_op
`endif
  );

  modport slave (
    input  instr_valid, opcode, z, mem_ready,
    output instr_ready, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_to_reg, reg_write, beq, branch_taken, mem_err, busy
`ifdef CU_ILLEGAL_TRAP_EN
    , output illegal_op
`endif
  );

endinterface

// File: rtl/cu_decode.sv
// Combinational opcode decode: instruction class plus ALU operation.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int ALU_OP_W = 2
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output instr_class_e        class_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  logic [2:0] op_lo;
  alu_op_e    alu_op;

  assign op_lo = opcode_i[2:0];

  always_comb begin
    class_o = CLS_ILLEGAL;
    alu_op  = ALU_ADD;
    if (is_legal(32'(opcode_i))) begin
      case (opcode_e'(op_lo))
        OPC_LW:  begin class_o = CLS_MEM_LD; alu_op = ALU_ADD; end
        OPC_SW:  begin class_o = CLS_MEM_ST; alu_op = ALU_ADD; end
        OPC_ADD: begin class_o = CLS_ALU;    alu_op = ALU_ADD; end
        OPC_SUB: begin class_o = CLS_ALU;    alu_op = ALU_SUB; end
        OPC_AND: begin class_o = CLS_ALU;    alu_op = ALU_AND; end
        OPC_OR:  begin class_o = CLS_ALU;    alu_op = ALU_OR;  end
        OPC_BEQ: begin class_o = CLS_BR;     alu_op = ALU_SUB; end
        default: begin class_o = CLS_ILLEGAL; alu_op = ALU_ADD; end
      endcase
    end
  end

  assign alu_op_o = ALU_OP_W'(alu_op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM control unit sequencing FETCH/DECODE/EXEC/MEM/WB.
// Define CU_ILLEGAL_TRAP_EN to trap illegal opcodes instead of treating them as NOPs.
//
// state  | meaning
// FETCH  | waiting for an opcode handshake
// DECODE | one bubble cycle, opcode classified
// EXEC   | ALU driven from latched opcode, branch resolved
// MEM    | data memory access, waits on mem_ready or timeout
// WB     | register file write
// TRAP   | illegal opcode seen, left only by reset (optional)
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int ALU_OP_W    = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  multicycle_control_unit_if.slave  cu_if
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
  localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
  localparam logic [2:0] S_EXEC   = 3'(ST_EXEC);
  localparam logic [2:0] S_MEM    = 3'(ST_MEM);
  localparam logic [2:0] S_WB     = 3'(ST_WB);
`ifdef CU_ILLEGAL_TRAP_EN
  localparam logic [2:0] S_TRAP   = 3'(ST_TRAP);
`endif

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  instr_class_e        dec_class;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                mem_timeout;
  logic                handshake;

  logic                instr_ready;
  logic                ir_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_write;
  logic                beq;
  logic                branch_taken;
  logic                mem_err;
  logic                busy;
  logic                illegal_op;

  cu_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode_i (opcode_q),
    .class_o  (dec_class),
    .alu_op_o (dec_alu_op)
  );

  // A zero timeout disables the limit; the counter still saturates harmlessly.
  assign mem_timeout = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign handshake   = cu_if.instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    wait_cnt_d = '0;
    case (state_q)
      S_FETCH: begin
        if (handshake) begin
          opcode_d = cu_if.opcode;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_class == CLS_ILLEGAL) begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_class)
          CLS_MEM_LD, CLS_MEM_ST: state_d = S_MEM;
          CLS_ALU:                state_d = S_WB;
          default:                state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (cu_if.mem_ready) begin
          state_d = (dec_class == CLS_MEM_LD) ? S_WB : S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_FETCH;
        end else begin
          wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
      end
      S_WB: state_d = S_FETCH;
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      opcode_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Every output is held low while reset is asserted so no pulse escapes an aborted instruction.
  always_comb begin
    instr_ready  = 1'b0;
    ir_write     = 1'b0;
    alu_op       = '0;
    alu_src      = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    beq          = 1'b0;
    branch_taken = 1'b0;
    mem_err      = 1'b0;
    busy         = 1'b0;
    illegal_op   = 1'b0;
    if (rst_n) begin
      busy = (state_q != S_FETCH);
      case (state_q)
        S_FETCH: begin
          instr_ready = 1'b1;
          ir_write    = cu_if.instr_valid;
        end
        S_EXEC: begin
          alu_op       = dec_alu_op;
          alu_src      = (dec_class == CLS_MEM_LD) || (dec_class == CLS_MEM_ST);
          beq          = (dec_class == CLS_BR);
          branch_taken = (dec_class == CLS_BR) && cu_if.z;
        end
        S_MEM: begin
          alu_op    = dec_alu_op;
          alu_src   = 1'b1;
          mem_read  = (dec_class == CLS_MEM_LD);
          mem_write = (dec_class == CLS_MEM_ST);
          mem_err   = mem_timeout && !cu_if.mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (dec_class == CLS_MEM_LD);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        S_TRAP: illegal_op = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign cu_if.instr_ready  = instr_ready;
  assign cu_if.ir_write     = ir_write;
  assign cu_if.alu_op       = alu_op;
  assign cu_if.alu_src      = alu_src;
  assign cu_if.mem_read     = mem_read;
  assign cu_if.mem_write    = mem_write;
  assign cu_if.mem_to_reg   = mem_to_reg;
  assign cu_if.reg_write    = reg_write;
  assign cu_if.beq          = beq;
  assign cu_if.branch_taken = branch_taken;
  assign cu_if.mem_err      = mem_err;
  assign cu_if.busy         = busy;
`ifdef CU_ILLEGAL_TRAP_EN
  assign cu_if.illegal_op   = illegal_op;
`else
  logic unused_illegal_op;
  assign unused_illegal_op = illegal_op;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction timeline model, directed and random opcodes.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  localparam int T = 16;
`ifdef CU_ILLEGAL_TRAP_EN
  localparam int MAX_OP = 6;
`else
  localparam int MAX_OP = 7;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(3), .ALU_OP_W(2)) cu_if ();

  multicycle_control_unit #(
    .OPCODE_W    (3),
    .ALU_OP_W    (2),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu_if (cu_if)
  );

  typedef struct packed {
    logic       ready;
    logic       irw;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       rw;
    logic       beq;
    logic       bt;
    logic       merr;
    logic       busy;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] opcode;
    logic       z;
    logic       mr;
    out_t       exp;
  } step_t;

  step_t plan[$];
  int errors = 0;
  int checks = 0;
  int step_no = 0;

  function automatic out_t idle_exp();
    out_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic out_t busy_exp();
    out_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  // Inputs that should not matter in a given cycle are randomised.
  function automatic step_t mk(input logic v, input logic [2:0] op, input out_t e);
    step_t s;
    s.valid  = v;
    s.opcode = op;
    s.z      = 1'($urandom);
    s.mr     = 1'($urandom);
    s.exp    = e;
    return s;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.ready   = cu_if.instr_ready;
    o.irw     = cu_if.ir_write;
    o.alu_op  = cu_if.alu_op;
    o.alu_src = cu_if.alu_src;
    o.mrd     = cu_if.mem_read;
    o.mwr     = cu_if.mem_write;
    o.m2r     = cu_if.mem_to_reg;
    o.rw      = cu_if.reg_write;
    o.beq     = cu_if.beq;
    o.bt      = cu_if.branch_taken;
    o.merr    = cu_if.mem_err;
    o.busy    = cu_if.busy;
`ifdef CU_ILLEGAL_TRAP_EN
    o.ill     = cu_if.illegal_op;
`else
    o.ill     = 1'b0;
`endif
    return o;
  endfunction

  task automatic check(input string tag, input out_t got, input out_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Timeline of one instruction, cycle 0 = handshake, ending with one idle FETCH cycle.
  // n = number of extra mem_ready wait cycles; n >= T means the access times out.
  task automatic plan_instr(input logic [2:0] op, input logic z, input int n);
    out_t  e;
    step_t s;
    int    m;
    logic  err;
    e = idle_exp();
    e.irw = 1'b1;
    plan.push_back(mk(1'b1, op, e));
    plan.push_back(mk(1'b0, 3'($urandom), busy_exp()));
    if (op == 3'd7) begin
`ifdef CU_ILLEGAL_TRAP_EN
      e = busy_exp();
      e.ill = 1'b1;
      for (int i = 0; i < 6; i++) plan.push_back(mk(1'b1, 3'($urandom), e));
      return;
`endif
    end else if (op == 3'd6) begin
      e = busy_exp();
      e.alu_op = 2'd1;
      e.beq = 1'b1;
      e.bt = z;
      s = mk(1'b0, 3'd0, e);
      s.z = z;
      plan.push_back(s);
    end else if (op >= 3'd2) begin
      e = busy_exp();
      e.alu_op = 2'(op - 3'd2);
      plan.push_back(mk(1'b0, 3'd0, e));
      e = busy_exp();
      e.rw = 1'b1;
      plan.push_back(mk(1'b0, 3'd0, e));
    end else begin
      e = busy_exp();
      e.alu_src = 1'b1;
      plan.push_back(mk(1'b0, 3'd0, e));
      err = (n >= T);
      m = err ? T : n + 1;
      for (int j = 0; j < m; j++) begin
        e = busy_exp();
        e.alu_src = 1'b1;
        e.mrd = (op == 3'd0);
        e.mwr = (op == 3'd1);
        e.merr = err && (j == m - 1);
        s = mk(1'b0, 3'd0, e);
        s.mr = (j == n);
        plan.push_back(s);
      end
      if (op == 3'd0 && !err) begin
        e = busy_exp();
        e.rw = 1'b1;
        e.m2r = 1'b1;
        plan.push_back(mk(1'b0, 3'd0, e));
      end
    end
    plan.push_back(mk(1'b0, 3'($urandom), idle_exp()));
  endtask

  task automatic run_steps(input int count);
    step_t s;
    for (int i = 0; i < count && plan.size() > 0; i++) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      cu_if.instr_valid = s.valid;
      cu_if.opcode      = s.opcode;
      cu_if.z           = s.z;
      cu_if.mem_ready   = s.mr;
      @(negedge clk);
      check($sformatf("step%0d", step_no), observe(), s.exp);
      step_no++;
    end
    plan.delete();
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input int n);
    plan_instr(op, z, n);
    run_steps(1000);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cu_if.instr_valid = 1'b1;
    cu_if.mem_ready   = 1'b0;
    @(negedge clk);
    check({tag, "_during"}, observe(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cu_if.instr_valid = 1'b0;
    @(negedge clk);
    check({tag, "_after"}, observe(), idle_exp());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    rst_n = 1'b0;
    cu_if.instr_valid = 1'b0;
    cu_if.opcode      = 3'd0;
    cu_if.z           = 1'b0;
    cu_if.mem_ready   = 1'b0;
    @(negedge clk);
    check("reset_hold", observe(), '0);
    do_reset("reset_init");

    run_instr(3'd2, 1'b0, 0);   // ADD
    run_instr(3'd0, 1'b0, 3);   // LW, three wait cycles
    run_instr(3'd6, 1'b1, 0);   // BEQ taken
    run_instr(3'd6, 1'b0, 0);   // BEQ not taken
    run_instr(3'd1, 1'b0, 99);  // SW timeout
    run_instr(3'd1, 1'b0, T-1); // SW ready on last allowed cycle
    run_instr(3'd0, 1'b0, T);   // LW timeout, no writeback
    run_instr(3'd0, 1'b0, 0);   // LW no wait
    run_instr(3'd5, 1'b1, 0);   // OR

    // Abort an LW stuck in MEM.
    plan_instr(3'd0, 1'b0, 99);
    run_steps(5);
    do_reset("reset_mid_mem");
    run_steps(0);
    plan.push_back(mk(1'b0, 3'd0, idle_exp()));
    run_steps(1);

    for (int k = 0; k < 40; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        plan.push_back(mk(1'b0, 3'($urandom), idle_exp()));
      op = 3'($urandom_range(0, MAX_OP));
      plan_instr(op, 1'($urandom), int'($urandom_range(0, 20)));
      run_steps(1000);
    end

    run_instr(3'd7, 1'b0, 0);   // illegal: NOP or TRAP
`ifdef CU_ILLEGAL_TRAP_EN
    do_reset("reset_trap");
    run_instr(3'd3, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
